product_accumulator: RTL and testbench
======================================

PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

Interface
REQ-001 The block SHALL have parameter SIZE, default 4: operand width of the upstream tree_multiplier; the product is 2*SIZE bits.
REQ-002 The block SHALL have parameter COUNT, default 4: products summed per result, legal range >= 1.
REQ-003 The block SHALL have parameter ACC_WIDTH, default 16: accumulator and result width, legal range >= 2*SIZE.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port clear, input, 1 bit: synchronous abort of the current accumulation.
REQ-007 The block SHALL have port in_valid, input, 1 bit: product/product_over valid.
REQ-008 The block SHALL have port in_ready, output, 1 bit: block accepts a product this cycle.
REQ-009 The block SHALL have port product, input, 2*SIZE bits: multiplier result c.
REQ-010 The block SHALL have port product_over, input, 1 bit: multiplier over flag.
REQ-011 The block SHALL have port out_valid, output, 1 bit: sum/sum_over valid.
REQ-012 The block SHALL have port out_ready, input, 1 bit: consumer takes the result.
REQ-013 The block SHALL have port sum, output, ACC_WIDTH bits: accumulated result.
REQ-014 The block SHALL have port sum_over, output, 1 bit: sticky overflow for the result.

Function
REQ-015 An input transfer SHALL occur on a rising edge with in_valid=1, in_ready=1 and clear=0.
REQ-016 An output transfer SHALL occur on a rising edge with out_valid=1 and out_ready=1.
REQ-017 The FSM SHALL have states IDLE, ACCUM and DONE.
REQ-018 in_ready SHALL be 1 in IDLE and ACCUM and 0 in DONE, decoded from state only and independent of out_ready.
REQ-019 On a transfer in IDLE, acc SHALL be loaded with the zero-extended product, count set to 1 and over set to product_over; next state is DONE if COUNT==1, else ACCUM.
REQ-020 On a transfer in ACCUM, acc SHALL become acc + product modulo 2^ACC_WIDTH, over SHALL become over OR product_over OR the carry out of bit ACC_WIDTH-1, and count SHALL increment; the state moves to DONE when count reaches COUNT.
REQ-021 Without a transfer in IDLE or ACCUM, acc, count, over and state SHALL hold.
REQ-022 In DONE, out_valid SHALL be 1, sum SHALL equal acc and sum_over SHALL equal over; all three stay stable until the output transfer.
REQ-023 On the output transfer, the state SHALL go to IDLE and acc, count and over SHALL clear to 0.
REQ-024 out_valid SHALL be registered and assert in the cycle after the COUNT-th input transfer, giving a latency of 1 cycle.
REQ-025 Outside DONE, out_valid and sum_over SHALL be 0 and sum SHALL be 0.
REQ-026 clear SHALL have priority over all transfers: state goes to IDLE, acc, count and over go to 0, and a same-cycle input or output handshake is discarded.
REQ-027 count SHALL be $clog2(COUNT+1) bits wide and SHALL never exceed COUNT.

Reset
REQ-028 While rst_n=0, the state SHALL be IDLE and acc, count, over, out_valid, sum and sum_over SHALL be 0; in_ready SHALL be 1.
REQ-029 Reset asserted mid-accumulation or in DONE SHALL discard all partial or pending results, with no output transfer.
REQ-030 After rst_n deasserts, the first rising edge SHALL be able to accept a product.

Structure
REQ-031 A shared package SHALL hold the FSM state enum (IDLE, ACCUM, DONE).
REQ-032 The block SHALL contain no sub-module; the adder and carry are inline and the multiplier is instantiated by the parent.

Verification
REQ-033 With SIZE=4, COUNT=4 and ACC_WIDTH=16, products 0x0F, 0x1E, 0x2D, 0x3C back-to-back SHALL give out_valid one cycle after the 4th, with sum=0x0096 and sum_over=0.
REQ-034 With ACC_WIDTH=8, four products 0xE1 SHALL give sum=0x84 and sum_over=1.
REQ-035 A product_over=1 on the 2nd product of 4 with no arithmetic carry SHALL give sum_over=1 at the result.
REQ-036 With out_ready held 0 for 3 cycles in DONE, sum and sum_over SHALL stay stable, in_ready=0 and an offered product SHALL be ignored; at out_ready=1 the block SHALL return to IDLE and accept the next product.
REQ-037 clear after 2 of 4 products, with in_valid=1 that cycle, SHALL return the block to IDLE with that product dropped; a fresh set of 0x01 x4 SHALL give sum=0x0004.
REQ-038 rst_n pulsed low asynchronously mid-ACCUM and in DONE SHALL immediately drive out_valid=0, sum=0 and in_ready=1.

Source files
------------

// File: rtl/product_accumulator_pkg.sv
// Shared types for the product accumulator.
// FSM state encoding used by the accumulator datapath.
package product_accumulator_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/product_accumulator.sv
// Sums COUNT multiplier products into one result with a sticky overflow flag.
// Valid/ready on both sides; clear aborts the running accumulation.
module product_accumulator
  import product_accumulator_pkg::*;
#(
  parameter int SIZE      = 4,
  parameter int COUNT     = 4,
  parameter int ACC_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2*SIZE-1:0]    product,
  input  logic                 product_over,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] sum,
  output logic                 sum_over
);

  localparam int CW = $clog2(COUNT + 1);

  state_e               r_state;
  state_e               w_state_nxt;
  logic [ACC_WIDTH-1:0] r_acc;
  logic [ACC_WIDTH-1:0] w_acc_nxt;
  logic [CW-1:0]        r_count;
  logic [CW-1:0]        w_count_nxt;
  logic                 r_over;
  logic                 w_over_nxt;

  logic                 w_in_xfer;
  logic                 w_last;
  logic                 w_done;
  logic [ACC_WIDTH-1:0] w_prod_ext;
  logic [ACC_WIDTH:0]   w_add;

  assign w_done     = (r_state == DONE);
  assign in_ready   = ~w_done;
  assign w_in_xfer  = in_valid & in_ready & ~clear;
  assign w_prod_ext = ACC_WIDTH'(product);
  // Extra MSB of the adder is the carry out of the accumulator.
  assign w_add      = {1'b0, r_acc} + {1'b0, w_prod_ext};
  assign w_last     = (r_count == CW'(COUNT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_acc   <= '0;
      r_count <= '0;
      r_over  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      r_count <= w_count_nxt;
      r_over  <= w_over_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_count_nxt = r_count;
    w_over_nxt  = r_over;
    if (clear) begin
      w_state_nxt = IDLE;
      w_acc_nxt   = '0;
      w_count_nxt = '0;
      w_over_nxt  = 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_in_xfer) begin
            w_acc_nxt   = w_prod_ext;
            w_count_nxt = CW'(1);
            w_over_nxt  = product_over;
            w_state_nxt = (COUNT == 1) ? DONE : ACCUM;
          end
        end
        ACCUM: begin
          if (w_in_xfer) begin
            w_acc_nxt   = w_add[ACC_WIDTH-1:0];
            w_over_nxt  = r_over | product_over
                        | w_add[ACC_WIDTH];
            w_count_nxt = r_count + CW'(1);
            if (w_last) begin
              w_state_nxt = DONE;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            w_state_nxt = IDLE;
            w_acc_nxt   = '0;
            w_count_nxt = '0;
            w_over_nxt  = 1'b0;
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_acc_nxt   = '0;
          w_count_nxt = '0;
          w_over_nxt  = 1'b0;
        end
      endcase
    end
  end

  // Result is only presented while the state register says DONE.
  assign out_valid = w_done;
  assign sum       = w_done ? r_acc : '0;
  assign sum_over  = w_done & r_over;

endmodule

// File: tb/tb_product_accumulator.sv
// Directed scoreboard bench for product_accumulator.
// A 16-bit and an 8-bit accumulator instance share clock, reset and clear.
module tb_product_accumulator;

  logic        clk;
  logic        rst_n;
  logic        clear;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  product;
  logic        product_over;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        sum_over;

  logic        v8;
  logic        rdy8;
  logic [7:0]  p8;
  logic        ov8;
  logic        oval8;
  logic        ordy8;
  logic [7:0]  sum8;
  logic        sov8;

  int n_total = 0;
  int n_pass  = 0;

  logic [16:0] q[$];
  logic [15:0] m_acc;
  logic        m_over;
  int          m_cnt;

  product_accumulator #(
    .SIZE(4), .COUNT(4), .ACC_WIDTH(16)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready),
    .product(product), .product_over(product_over),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .sum_over(sum_over)
  );

  product_accumulator #(
    .SIZE(4), .COUNT(4), .ACC_WIDTH(8)
  ) u_dut8 (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(v8), .in_ready(rdy8),
    .product(p8), .product_over(ov8),
    .out_valid(oval8), .out_ready(ordy8),
    .sum(sum8), .sum_over(sov8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h want %0h",
                tag, obs, exp);
  endtask

  task automatic model_reset();
    m_cnt  = 0;
    m_acc  = '0;
    m_over = 1'b0;
  endtask

  task automatic push(input logic [7:0] p,
                      input logic ov);
    logic [16:0] t;
    chk("in_ready_before_push", 32'(in_ready), 1);
    in_valid     = 1'b1;
    product      = p;
    product_over = ov;
    @(posedge clk);
    #1;
    in_valid     = 1'b0;
    product      = '0;
    product_over = 1'b0;
    if (m_cnt == 0) begin
      m_acc  = {8'h00, p};
      m_over = ov;
    end else begin
      t      = {1'b0, m_acc} + {9'h000, p};
      m_acc  = t[15:0];
      m_over = m_over | ov | t[16];
    end
    m_cnt++;
    if (m_cnt == 4) begin
      q.push_back({m_over, m_acc});
      model_reset();
    end
  endtask

  task automatic expect_result(input string tag);
    logic [16:0] e;
    int k;
    k = 0;
    while (out_valid !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_valid"}, 32'(out_valid), 1);
    chk({tag, "_qdepth"}, 32'(q.size()), 1);
    if (q.size() > 0) begin
      e = q.pop_front();
      chk({tag, "_sum"}, 32'(sum), 32'(e[15:0]));
      chk({tag, "_over"}, 32'(sum_over), 32'(e[16]));
    end
    chk({tag, "_in_ready_done"}, 32'(in_ready), 0);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, "_idle_valid"}, 32'(out_valid), 0);
    chk({tag, "_idle_sum"}, 32'(sum), 0);
    chk({tag, "_idle_ready"}, 32'(in_ready), 1);
  endtask

  initial begin
    rst_n        = 1'b0;
    clear        = 1'b0;
    in_valid     = 1'b0;
    product      = '0;
    product_over = 1'b0;
    out_ready    = 1'b0;
    v8    = 1'b0;
    p8    = '0;
    ov8   = 1'b0;
    ordy8 = 1'b0;
    model_reset();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_sum", 32'(sum), 0);
    chk("rst_sum_over", 32'(sum_over), 0);
    rst_n = 1'b1;

    // Back-to-back set, first edge after reset
    push(8'h0F, 1'b0);
    push(8'h1E, 1'b0);
    push(8'h2D, 1'b0);
    chk("pre_last_valid", 32'(out_valid), 0);
    chk("pre_last_sum", 32'(sum), 0);
    push(8'h3C, 1'b0);
    chk("latency_valid", 32'(out_valid), 1);
    chk("basic_sum_const", 32'(sum), 32'h0096);
    expect_result("basic");

    // Sticky product_over on the 2nd product
    push(8'h01, 1'b0);
    push(8'h02, 1'b1);
    push(8'h03, 1'b0);
    push(8'h04, 1'b0);
    chk("pover_const", 32'(sum_over), 1);
    expect_result("pover");

    // Backpressure in DONE with an offered product
    push(8'h10, 1'b0);
    push(8'h20, 1'b0);
    push(8'h30, 1'b0);
    push(8'h40, 1'b0);
    in_valid = 1'b1;
    product  = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("bp_sum", 32'(sum), 32'h00A0);
      chk("bp_over", 32'(sum_over), 0);
      chk("bp_in_ready", 32'(in_ready), 0);
      chk("bp_valid", 32'(out_valid), 1);
    end
    in_valid = 1'b0;
    product  = '0;
    expect_result("bp");
    push(8'h05, 1'b0);
    push(8'h05, 1'b0);
    push(8'h05, 1'b0);
    push(8'h05, 1'b0);
    chk("after_bp_const", 32'(sum), 32'h0014);
    expect_result("after_bp");

    // Clear mid-accumulation drops the same-cycle product
    push(8'h01, 1'b0);
    push(8'h01, 1'b0);
    clear    = 1'b1;
    in_valid = 1'b1;
    product  = 8'h55;
    @(posedge clk);
    #1;
    clear    = 1'b0;
    in_valid = 1'b0;
    product  = '0;
    model_reset();
    chk("clr_in_ready", 32'(in_ready), 1);
    chk("clr_valid", 32'(out_valid), 0);
    push(8'h01, 1'b0);
    push(8'h01, 1'b0);
    push(8'h01, 1'b0);
    push(8'h01, 1'b0);
    chk("clr_fresh_const", 32'(sum), 32'h0004);
    expect_result("clr_fresh");

    // Clear in DONE beats a same-cycle output handshake
    push(8'h07, 1'b0);
    push(8'h07, 1'b0);
    push(8'h07, 1'b0);
    push(8'h07, 1'b0);
    chk("clr_done_pre", 32'(out_valid), 1);
    clear     = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    clear     = 1'b0;
    out_ready = 1'b0;
    q.delete();
    chk("clr_done_valid", 32'(out_valid), 0);
    chk("clr_done_ready", 32'(in_ready), 1);

    // Asynchronous reset mid-ACCUM
    push(8'h11, 1'b0);
    push(8'h22, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_acc_valid", 32'(out_valid), 0);
    chk("arst_acc_sum", 32'(sum), 0);
    chk("arst_acc_ready", 32'(in_ready), 1);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Asynchronous reset in DONE
    push(8'h33, 1'b0);
    push(8'h33, 1'b0);
    push(8'h33, 1'b0);
    push(8'h33, 1'b0);
    chk("arst_done_pre", 32'(out_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_done_valid", 32'(out_valid), 0);
    chk("arst_done_sum", 32'(sum), 0);
    chk("arst_done_ready", 32'(in_ready), 1);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    push(8'h02, 1'b0);
    push(8'h03, 1'b0);
    push(8'h04, 1'b0);
    push(8'h05, 1'b0);
    expect_result("post_arst");

    // 8-bit accumulator wraps and flags overflow
    for (int i = 0; i < 4; i++) begin
      chk("w8_in_ready", 32'(rdy8), 1);
      v8 = 1'b1;
      p8 = 8'hE1;
      @(posedge clk);
      #1;
    end
    v8 = 1'b0;
    p8 = '0;
    chk("w8_valid", 32'(oval8), 1);
    chk("w8_sum", 32'(sum8), 32'h84);
    chk("w8_over", 32'(sov8), 1);
    ordy8 = 1'b1;
    @(posedge clk);
    #1;
    ordy8 = 1'b0;
    chk("w8_idle_valid", 32'(oval8), 0);
    chk("w8_idle_over", 32'(sov8), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
